// File: rtl/dummy_packer_if.sv
// dummy_packer_if: narrow-in / wide-out valid-ready bundle for dummy_packer.
// last_i and out_fill_o exist only when PACKER_FLUSH_EN is defined.
interface dummy_packer_if #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 32
);
    localparam int RATIO = DATA_W / IN_W;
    localparam int CW    = $clog2(RATIO);
    logic [IN_W-1:0]   in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CW-1:0]     beat_cnt_o;
`ifdef PACKER_FLUSH_EN
    logic              last_i;
    logic [CW:0]       out_fill_o;
    modport slave (
        input  in_data_i, in_valid_i, out_ready_i, last_i,
        output in_ready_o, out_data_o, out_valid_o, beat_cnt_o, out_fill_o
    );
    modport master (
        output in_data_i, in_valid_i, out_ready_i, last_i,
        input  in_ready_o, out_data_o, out_valid_o, beat_cnt_o, out_fill_o
    );
`else
    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, beat_cnt_o
    );
    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, beat_cnt_o
    );
`endif
endinterface

// File: rtl/dummy_packer.sv
// dummy_packer: packs RATIO narrow IN_W beats (beat 0 in LSBs) into one DATA_W word.
// PACKER_FLUSH_EN: last_i closes a partial zero-padded word, out_fill_o reports its beat count.
module dummy_packer #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 32
) (
    input  logic           clk_i,
    input  logic           reset_i,
    dummy_packer_if.slave  bus
);
    localparam int RATIO = DATA_W / IN_W;
    localparam int CW    = $clog2(RATIO);
    localparam int AW    = DATA_W - IN_W;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_acc;
    logic [DATA_W-1:0] r_out;
    logic              r_vld;
    logic [DATA_W-1:0] w_word;
    logic              w_last;
    logic              w_full;
    logic              w_ready;
    logic              w_take;
    logic              w_close;
`ifdef PACKER_FLUSH_EN
    logic [CW:0]       r_fill;
    assign w_last = bus.last_i;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_fill <= '0;
        else if (w_close)
            r_fill <= {1'b0, r_cnt} + 1'b1;
    end
    assign bus.out_fill_o = r_fill;
`else
    assign w_last = 1'b0;
`endif
    // Accumulator upper beats are always zero, so OR-ing the shifted beat builds the word.
    always_comb begin
        w_full  = r_cnt == CW'(RATIO - 1);
        w_ready = (!w_full && !w_last) || !r_vld || bus.out_ready_i;
        w_take  = bus.in_valid_i && w_ready;
        w_close = w_take && (w_full || w_last);
        w_word  = {{IN_W{1'b0}}, r_acc} | (DATA_W'(bus.in_data_i) << (int'(r_cnt) * IN_W));
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_out <= '0;
            r_vld <= 1'b0;
        end else if (w_close) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_out <= w_word;
            r_vld <= 1'b1;
        end else begin
            if (w_take) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_word[AW-1:0];
            end
            if (bus.out_ready_i)
                r_vld <= 1'b0;
        end
    end
    assign bus.in_ready_o  = w_ready;
    assign bus.out_data_o  = r_out;
    assign bus.out_valid_o = r_vld;
    assign bus.beat_cnt_o  = r_cnt;
endmodule

// File: tb/tb_dummy_packer.sv
// tb_dummy_packer: randomized scoreboard bench for dummy_packer (DATA_W=128, IN_W=32).
module tb_dummy_packer;
    localparam int DW = 128;
    localparam int IW = 32;
    localparam int R  = DW / IW;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [IW-1:0] beats[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int exp_f[$];
    int got_f[$];
    logic tb_last;
    always #5 clk = ~clk;
    dummy_packer_if #(.DATA_W(DW), .IN_W(IW)) bus ();
    dummy_packer #(.DATA_W(DW), .IN_W(IW)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
`ifdef PACKER_FLUSH_EN
    assign tb_last = bus.last_i;
`else
    assign tb_last = 1'b0;
`endif
    // Reference model: collect accepted beats, emit a word per RATIO beats (or on last).
    always @(negedge clk) begin
        if (rst) begin
            beats.delete();
            exp_q.delete();
            exp_f.delete();
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                got_q.push_back(bus.out_data_o);
`ifdef PACKER_FLUSH_EN
                got_f.push_back(int'(bus.out_fill_o));
`endif
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                beats.push_back(bus.in_data_i);
                if (beats.size() == R || tb_last) begin
                    logic [DW-1:0] w;
                    w = '0;
                    foreach (beats[k]) w[k*IW +: IW] = beats[k];
                    exp_q.push_back(w);
                    exp_f.push_back(beats.size());
                    beats.delete();
                end
            end
        end
    end
    task automatic put(input logic [IW-1:0] d, input logic l);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
`ifdef PACKER_FLUSH_EN
        bus.last_i = l;
`endif
        for (int t = 0; t <= 50; t++) begin
            @(negedge clk);
            if (bus.in_ready_o) break;
            if (t == 50) begin
                errors++;
                $display("FAIL put_timeout in_ready_o stuck at 0, need 1");
            end
        end
    endtask
    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.last_i = 1'b0;
`endif
    endtask
    task automatic test_reset();
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 32'hDEADBEEF;
        bus.out_ready_i = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.last_i = 1'b0;
`endif
        #20;
        checks += 3;
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b need 0", bus.out_valid_o); end
        if (bus.out_data_o !== '0) begin errors++; $display("FAIL rst_data got %h need 0", bus.out_data_o); end
        if (bus.beat_cnt_o !== '0) begin errors++; $display("FAIL rst_cnt got %0d need 0", bus.beat_cnt_o); end
`ifdef PACKER_FLUSH_EN
        checks++;
        if (bus.out_fill_o !== '0) begin errors++; $display("FAIL rst_fill got %0d need 0", bus.out_fill_o); end
`endif
        #13;
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.beat_cnt_o !== '0) begin errors++; $display("FAIL post_rst_cnt got %0d need 0", bus.beat_cnt_o); end
        if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b need 1", bus.in_ready_o); end
    endtask
    task automatic test_basic();
        bus.out_ready_i = 1'b1;
        put(32'h11111111, 1'b0);
        put(32'h22222222, 1'b0);
        put(32'h33333333, 1'b0);
        put(32'h44444444, 1'b0);
        idle();
        checks += 3;
        if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b need 1", bus.out_valid_o); end
        if (bus.out_data_o !== 128'h44444444_33333333_22222222_11111111)
            begin errors++; $display("FAIL basic_data got %h need 44444444333333332222222211111111", bus.out_data_o); end
        if (bus.beat_cnt_o !== '0) begin errors++; $display("FAIL basic_cnt got %0d need 0", bus.beat_cnt_o); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drop got %b need 0", bus.out_valid_o); end
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL basic_count got %0d need %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
    task automatic test_stream();
        int rdy_low = 0;
        int vcnt = 0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3 * R; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = $urandom;
            @(negedge clk);
            if (!bus.in_ready_o) rdy_low++;
            if (bus.out_valid_o) vcnt++;
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            @(negedge clk);
            if (bus.out_valid_o) vcnt++;
        end
        checks += 2;
        if (rdy_low != 0) begin errors++; $display("FAIL stream_ready_low got %0d need 0", rdy_low); end
        if (vcnt != 3) begin errors++; $display("FAIL stream_valid_cycles got %0d need 3", vcnt); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_count got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_word%0d got %h need %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
    task automatic test_stall();
        logic [IW-1:0] b[8];
        logic [DW-1:0] w1, w2;
        int idx = 0;
        int unstable = 0;
        foreach (b[k]) b[k] = $urandom;
        w1 = {b[3], b[2], b[1], b[0]};
        w2 = {b[7], b[6], b[5], b[4]};
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk);
            #1;
            bus.out_ready_i = (cyc >= 10);
            bus.in_valid_i  = (idx < 8);
            bus.in_data_i   = (idx < 8) ? b[idx] : '0;
            @(negedge clk);
            if (cyc >= 4 && cyc <= 9 && bus.out_data_o !== w1) unstable++;
            if (cyc == 9) begin
                checks += 3;
                if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %b need 0", bus.in_ready_o); end
                if (bus.beat_cnt_o !== 2'd3) begin errors++; $display("FAIL stall_cnt got %0d need 3", bus.beat_cnt_o); end
                if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got %b need 1", bus.out_valid_o); end
            end
            if (cyc == 10) begin
                checks++;
                if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %b need 1", bus.in_ready_o); end
            end
            if (cyc == 11) begin
                checks += 2;
                if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL release_valid got %b need 1", bus.out_valid_o); end
                if (bus.out_data_o !== w2) begin errors++; $display("FAIL release_data got %h need %h", bus.out_data_o, w2); end
            end
            if (bus.in_valid_i && bus.in_ready_o) idx++;
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL stall_hold got %0d changes need 0", unstable); end
        checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL stall_count got %0d need 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d got %h need %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
    task automatic test_reset_mid();
        bus.out_ready_i = 1'b1;
        put($urandom, 1'b0);
        put($urandom, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b need 0", bus.out_valid_o); end
        if (bus.out_data_o !== '0) begin errors++; $display("FAIL midrst_data got %h need 0", bus.out_data_o); end
        if (bus.beat_cnt_o !== '0) begin errors++; $display("FAIL midrst_cnt got %0d need 0", bus.beat_cnt_o); end
        #2;
        rst = 1'b0;
        got_q.delete();
        for (int i = 0; i < R; i++) put($urandom, 1'b0);
        idle();
        idle();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL midrst_count got %0d need 1", got_q.size()); end
        if (got_q.size() == 1 && exp_q.size() == 1) begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_word got %h need %h", got_q[0], exp_q[0]); end
        end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
    task automatic test_random();
        logic pv = 1'b0, pr = 1'b0;
        logic [DW-1:0] pd = '0;
        int viol = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk);
            #1;
            bus.in_valid_i  = ($urandom_range(0, 9) < 7);
            bus.in_data_i   = $urandom;
            bus.out_ready_i = $urandom_range(0, 1);
            @(negedge clk);
            if (pv && !pr && (!bus.out_valid_o || bus.out_data_o !== pd)) viol++;
            pv = bus.out_valid_o;
            pr = bus.out_ready_i;
            pd = bus.out_data_o;
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < R && beats.size() != 0; i++) put($urandom, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL random_hold got %0d violations need 0", viol); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d need %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d got %h need %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
`ifdef PACKER_FLUSH_EN
    task automatic test_flush_partial();
        bus.out_ready_i = 1'b1;
        put(32'hAAAAAAAA, 1'b0);
        put(32'hBBBBBBBB, 1'b1);
        idle();
        checks += 4;
        if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid got %b need 1", bus.out_valid_o); end
        if (bus.out_data_o !== 128'h00000000_00000000_BBBBBBBB_AAAAAAAA)
            begin errors++; $display("FAIL flush_data got %h need 0000000000000000BBBBBBBBAAAAAAAA", bus.out_data_o); end
        if (bus.out_fill_o !== 3'd2) begin errors++; $display("FAIL flush_fill got %0d need 2", bus.out_fill_o); end
        if (bus.beat_cnt_o !== '0) begin errors++; $display("FAIL flush_cnt got %0d need 0", bus.beat_cnt_o); end
        idle();
        checks++;
        if (got_f.size() != exp_f.size() || (got_f.size() > 0 && got_f[0] != exp_f[0]))
            begin errors++; $display("FAIL flush_model_fill got %0d words need %0d", got_f.size(), exp_f.size()); end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
    task automatic test_flush_stall();
        int hi = 0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < R; i++) put($urandom, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 32'h5;
        bus.last_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) hi++;
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL flush_stall_ready got %0d high cycles need 0", hi); end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_drain_ready got %b need 1", bus.in_ready_o); end
        idle();
        checks += 3;
        if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL flush1_valid got %b need 1", bus.out_valid_o); end
        if (bus.out_data_o !== 128'h5) begin errors++; $display("FAIL flush1_data got %h need 5", bus.out_data_o); end
        if (bus.out_fill_o !== 3'd1) begin errors++; $display("FAIL flush1_fill got %0d need 1", bus.out_fill_o); end
        idle();
        checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL flush_stall_count got %0d need 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_f[i] != exp_f[i])
                begin errors++; $display("FAIL flush_stall_word%0d got %h/%0d need %h/%0d", i, got_q[i], got_f[i], exp_q[i], exp_f[i]); end
        end
        got_q.delete(); exp_q.delete(); got_f.delete(); exp_f.delete();
    endtask
`endif
    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef PACKER_FLUSH_EN
        test_flush_partial();
        test_flush_stall();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
